fixed_latency_arbiter: RTL and testbench
========================================

# fixed_latency_arbiter

Round-robin arbiter that shares one fixed-latency datapath (a pipeline of exactly LATENCY cycles with no backpressure) among NUM_REQ requesters. It accepts at most one request per cycle and issues it to the datapath. It carries the requester ID alongside the data through a matching tag delay line and steers each result back to its owner. A per-requester credit limit bounds outstanding operations, and no flow control is needed on the response side.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_W, 8, request/result data width
- LATENCY, 5, datapath latency in cycles (≥1), pipe_in to pipe_out
- MAX_OUT, 2, max outstanding operations per requester (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*DATA_W  request data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot-or-zero grant, combinational
- pipe_in_valid  out  1  issue strobe to datapath, registered
- pipe_in  out  DATA_W  issued data, registered
- pipe_out  in  DATA_W  datapath result, LATENCY cycles after pipe_in
- rsp_valid  out  NUM_REQ  one-hot-or-zero result strobe
- rsp_data  out  DATA_W  equals pipe_out, valid when any rsp_valid bit is set
- busy  out  1  any operation issued or in flight

## Operation
- Eligibility: requester i is eligible when req_valid[i] is set and credit is available.
  - Credit is available when cnt[i] < MAX_OUT, or when rsp_valid[i] is set this cycle (same-cycle credit return).
- Arbitration: grant goes to the first eligible index, searching from ptr upward with wrap to 0. req_ready is set only for the granted index. No eligible requester means no grant.
- Accept: occurs when req_valid[g] & req_ready[g]. On accept:
  - ptr <= (g+1) mod NUM_REQ; ptr is unchanged when there is no accept.
  - Issue register loads pipe_in <= req_data[g], pipe_in_valid <= 1, tag <= g.
- Without an accept: pipe_in_valid <= 0, and pipe_in holds its last value.
- Tag pipe: {pipe_in_valid, tag} is delayed LATENCY cycles, aligned with pipe_out. rsp_valid = onehot(tag_out) when valid_out is set, else 0.
- Credit counters: each cnt[i] has width clog2(MAX_OUT+1).
  - Increments on accept from i; decrements on rsp_valid[i].
  - When both happen in the same cycle, the count is unchanged.
  - Underflow and overflow cannot occur; the bench asserts this.
- busy = pipe_in_valid | (any cnt ≠ 0).
- Response side has no backpressure: results are always delivered on the cycle they emerge.

## Timing
- Request accepted at cycle t:
  - pipe_in_valid and pipe_in are high/valid at t+1.
  - rsp_valid[g] and rsp_data are valid at t+1+LATENCY.
- Throughput: 1 accept/cycle aggregate. A single requester alone sustains MAX_OUT accepts per (LATENCY+1) cycles.
- Reset values: req_ready is combinational from state, so it is 0 during reset. All registered outputs and state reset:
  - pipe_in_valid=0, pipe_in=0, rsp_valid=0, busy=0
  - ptr=0, every cnt=0, tag pipe all zeros
- Reset mid-operation:
  - All in-flight operations are discarded. rsp_valid stays 0 for every result the datapath emits afterwards.
  - Counters restart at 0.
  - Requests presented during reset are not accepted.

## Structure
- Shared package holds:
  - the ID width constant, clog2(NUM_REQ)
  - the counter width function
  - a round-robin find-first helper function
- Sub-module: tag pipe is one instance of the team's existing `latency` delay-line module, with WIDTH = 1+clog2(NUM_REQ) and LENGTH = LATENCY, carrying {valid, tag}.
- Remainder of the block: arbiter, issue register, credit counters and response decode.

## Test plan
Defaults apply (NUM_REQ=4, DATA_W=8, LATENCY=5, MAX_OUT=2). Datapath is modelled by a `latency` instance with pipe_out = pipe_in delayed by 5.
- Requester 1 alone, data 0xA5, accepted at t: pipe_in=0xA5 with pipe_in_valid at t+1; rsp_valid=4'b0010 and rsp_data=0xA5 at t+6; busy returns to 0 at t+7.
- All four valid continuously with distinct data: grants 0,1,2,3,0,… one per cycle; each rsp_valid returns 6 cycles after its accept with matching data.
- Requester 2 held valid alone: accepts at t and t+1; req_ready[2]=0 during t+2..t+5; accepted again at t+6 via same-cycle credit return.
- Requesters 0 and 3 valid, ptr=1: grant 3 first, then 0, then 3.
- Reset asserted at t+3 with three operations in flight: rsp_valid stays 0 through t+10; busy=0, ptr=0 and every cnt=0 at t+4.
- Random valid patterns for 10k cycles, checked against a scoreboard:
  - every accepted request returns exactly once, to the correct requester, in order;
  - every cnt stays ≤ MAX_OUT.

Source files
------------

// File: rtl/fixed_latency_arbiter_pkg.sv
// Shared constants and helpers for the fixed-latency arbiter.
// Width functions and the round-robin search used by the grant logic.
package fixed_latency_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int RR_MAX      = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(DEF_NUM_REQ);

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // First set bit of elig at or above ptr, wrapping; -1 when none.
    function automatic int rr_first(
        input logic [RR_MAX-1:0] elig,
        input int                n,
        input int                ptr
    );
        int idx;
        rr_first = -1;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (elig[idx[4:0]]) rr_first = idx;
        end
    endfunction

endpackage

// File: rtl/fixed_latency_arbiter_latency.sv
// Fixed-length delay line, cleared by synchronous reset.
// Output equals the input LENGTH clock cycles earlier.
module latency #(
    parameter int WIDTH  = 1,
    parameter int LENGTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] stage [LENGTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LENGTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= in_data;
            for (int k = 1; k < LENGTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign out_data = stage[LENGTH-1];

endmodule

// File: rtl/fixed_latency_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath.
// Requester IDs ride a tag delay line so results return to their owner.
module fixed_latency_arbiter
    import fixed_latency_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 5,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pipe_in_valid,
    output logic [DATA_W-1:0]         pipe_in,
    input  logic [DATA_W-1:0]         pipe_out,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = cnt_width(MAX_OUT);
    localparam int TW  = 1 + IDW;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     tag;
    logic [IDW-1:0]     tag_out;
    logic               valid_out;
    logic [CW-1:0]      cnt [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic               accept;
    logic [IDW-1:0]     gnt;
    int                 found;

    // A response this cycle frees its credit in time for a new grant.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i]
                   && ((cnt[i] < CW'(MAX_OUT)) || rsp_valid[i]);
        end
    end

    always_comb begin
        found  = rr_first(RR_MAX'(elig), NUM_REQ, int'(ptr));
        accept = !reset && (found >= 0);
        gnt    = found[IDW-1:0];
        req_ready = '0;
        if (accept) req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_in_valid <= 1'b0;
            pipe_in       <= '0;
            tag           <= '0;
            ptr           <= '0;
        end else begin
            pipe_in_valid <= accept;
            if (accept) begin
                pipe_in <= req_data[gnt*DATA_W +: DATA_W];
                tag     <= gnt;
                ptr     <= (gnt == IDW'(NUM_REQ - 1))
                         ? '0 : gnt + IDW'(1);
            end
        end
    end

    latency #(
        .WIDTH  (TW),
        .LENGTH (LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({pipe_in_valid, tag}),
        .out_data ({valid_out, tag_out})
    );

    always_comb begin
        rsp_valid = '0;
        if (valid_out) rsp_valid[tag_out] = 1'b1;
        rsp_data = pipe_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && !rsp_valid[i])
                    cnt[i] <= cnt[i] + CW'(1);
                else if (!req_ready[i] && rsp_valid[i])
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    always_comb begin
        busy = pipe_in_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt[i] != '0) busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_fixed_latency_arbiter.sv
// Bench for fixed_latency_arbiter: vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fixed_latency_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LAT = 5;
    localparam int MO  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            pipe_in_valid;
    logic [DW-1:0]   pipe_in;
    logic [DW-1:0]   pipe_out;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_latency_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .LATENCY (LAT),
        .MAX_OUT (MO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pipe_in_valid (pipe_in_valid),
        .pipe_in       (pipe_in),
        .pipe_out      (pipe_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy)
    );

    latency #(.WIDTH(DW), .LENGTH(LAT)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .in_data  (pipe_in),
        .out_data (pipe_out)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_cnt_zero();
        for (int i = 0; i < N; i++)
            chk("cnt_zero", 32'(dut.cnt[i]), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic [N-1:0] ready;
        logic [N-1:0] rsp;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
        int            due;
    } op_t;

    vec_t          tbl [11];
    logic [DW-1:0] sent [16];
    op_t           fifo [$];
    int            outst [N];

    initial begin
        int            mptr;
        int            g;
        int            tot;
        logic [N-1:0]  exp_rsp;
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] lane;
        op_t           op;

        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1001, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b1001, 4'b1000, 4'b0000};
        tbl[3]  = '{4'b1001, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b1001, 4'b1000, 4'b0000};
        tbl[5]  = '{4'b1001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1001, 4'b0001, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b1000, 4'b1000};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0001};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1000};

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset state, with requests presented during reset.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_piv", 32'(pipe_in_valid), 32'd0);
        chk("reset_pipe_in", 32'(pipe_in), 32'd0);
        chk("reset_rsp", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ptr", 32'(dut.ptr), 32'd0);
        check_cnt_zero();

        // Vector table: requesters 0 and 3 contend, credits run out.
        do_reset();
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int r = 0; r < 11; r++) begin
            req_valid = tbl[r].rv;
            @(negedge clk);
            chk("tbl_ready", 32'(req_ready), 32'(tbl[r].ready));
            chk("tbl_rsp", 32'(rsp_valid), 32'(tbl[r].rsp));
            if (tbl[r].rsp == 4'b0001)
                chk("tbl_rsp_data", 32'(rsp_data), 32'h30);
            if (tbl[r].rsp == 4'b1000)
                chk("tbl_rsp_data", 32'(rsp_data), 32'h33);
            next_cycle();
        end

        // Requester 1 alone, single operation.
        do_reset();
        req_data  = '0;
        req_data[1*DW +: DW] = 8'hA5;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("r1_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("r1_piv", 32'(pipe_in_valid), 32'd1);
        chk("r1_pipe_in", 32'(pipe_in), 32'hA5);
        chk("r1_busy_t1", 32'(busy), 32'd1);
        repeat (4) next_cycle();
        @(negedge clk);
        chk("r1_rsp_t5", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("r1_rsp_t6", 32'(rsp_valid), 32'b0010);
        chk("r1_data_t6", 32'(rsp_data), 32'hA5);
        chk("r1_busy_t6", 32'(busy), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("r1_busy_t7", 32'(busy), 32'd0);
        chk("r1_rsp_t7", 32'(rsp_valid), 32'd0);

        // Requester 2 held valid: credit stall, then same-cycle return.
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("r2_ready", 32'(req_ready),
                (c < 2 || c == 6) ? 32'b0100 : 32'd0);
            next_cycle();
        end

        // All four valid: strict rotation, responses six cycles later.
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                lane = 8'(c * 16 + i);
                req_data[i*DW +: DW] = lane;
            end
            sent[c] = 8'(c * 16 + (c % N));
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1 << (c % N)));
            if (c >= 1 + LAT) begin
                chk("rr_rsp", 32'(rsp_valid),
                    32'(1 << ((c - 1 - LAT) % N)));
                chk("rr_rsp_data", 32'(rsp_data),
                    32'(sent[c - 1 - LAT]));
            end
            next_cycle();
        end

        // Reset with three operations in flight.
        do_reset();
        req_valid = 4'hF;
        repeat (3) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_ready", 32'(req_ready), 32'd0);
        next_cycle();
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ptr", 32'(dut.ptr), 32'd0);
        check_cnt_zero();
        for (int c = 4; c <= 10; c++) begin
            @(negedge clk);
            chk("mid_rsp", 32'(rsp_valid), 32'd0);
            next_cycle();
        end

        // Randomized run against the reference model.
        do_reset();
        mptr = 0;
        fifo.delete();
        for (int i = 0; i < N; i++) outst[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            req_valid = (cyc < 9980) ? N'($urandom) : '0;
            req_data  = (N*DW)'($urandom);
            @(negedge clk);
            exp_rsp = '0;
            exp_d   = '0;
            if (fifo.size() > 0 && fifo[0].due == cyc) begin
                exp_rsp[fifo[0].id] = 1'b1;
                exp_d = fifo[0].d;
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mptr + k) % N;
                if (g < 0 && req_valid[idx]
                    && (outst[idx] < MO || exp_rsp[idx]))
                    g = idx;
            end
            exp_rdy = (g >= 0) ? N'(1 << g) : '0;
            tot = 0;
            for (int i = 0; i < N; i++) tot += outst[i];
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_rsp", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_rsp != '0)
                chk("rnd_rsp_data", 32'(rsp_data), 32'(exp_d));
            chk("rnd_busy", 32'(busy), 32'(tot > 0));
            for (int i = 0; i < N; i++)
                chk("rnd_cnt_bound",
                    32'(int'(dut.cnt[i]) <= MO), 32'd1);
            if (exp_rsp != '0) begin
                op = fifo.pop_front();
                outst[op.id]--;
            end
            if (g >= 0) begin
                op.id  = g;
                op.d   = req_data[g*DW +: DW];
                op.due = cyc + 1 + LAT;
                fifo.push_back(op);
                outst[g]++;
                mptr = (g + 1) % N;
            end
            next_cycle();
        end
        chk("rnd_drained", 32'(fifo.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
